ssd_display_scheduler: RTL and testbench

// Shares the 4-digit seven-segment display between NUM_REQ requesters.

---
 rtl/ssd_display_scheduler.sv | 172 +++++++++++++++++
 tb/tb_ssd_display_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_display_scheduler.sv
// Round-robin owner of the 4-digit seven-segment display. Converts the owner's
// 16-bit binary value to packed BCD with one double-dabble iteration per clock.
module ssd_display_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DWELL_CYCLES = 100_000_000,
    parameter int unsigned CNT_W        = 27
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [16*NUM_REQ-1:0]  value_flat_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [15:0]            bcd_out_o,
    output logic                   blank_o,
    output logic                   overflow_o,
    output logic                   busy_o
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned VAL_W  = 16;
    localparam int unsigned SH_W   = 36;
    localparam int unsigned ITER_W = 4;
    localparam int unsigned NIB_N  = 5;
    localparam logic [VAL_W-1:0] MAX_DEC = 16'd9999;

    typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_e;

    state_e               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [15:0]          bcd_q, bcd_d;
    logic                 blank_q, blank_d;
    logic                 ovf_q, ovf_d;
    logic                 busy_q, busy_d;
    logic [SH_W-1:0]      shreg_q, shreg_d;
    logic [ITER_W-1:0]    iter_q, iter_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [CNT_W-1:0]     dwell_q, dwell_d;

    logic [PTR_W-1:0]     win_c;
    logic [NUM_REQ-1:0]   win_onehot_c;
    logic [VAL_W-1:0]     win_val_c;
    logic [SH_W-1:0]      adj_c;
    logic [SH_W-1:0]      step_c;

    // Round-robin search starting just after the last winner
    always_comb begin
        int unsigned idx;
        logic        found;
        win_c = rr_ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = 32'(rr_ptr_q) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_i[PTR_W'(idx)]) begin
                found = 1'b1;
                win_c = PTR_W'(idx);
            end
        end
        win_onehot_c = '0;
        win_val_c    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (PTR_W'(i) == win_c) begin
                win_onehot_c[i] = 1'b1;
                win_val_c       = value_flat_i[i*VAL_W +: VAL_W];
            end
        end
    end

    // One double-dabble iteration: add-3 on nibbles >= 5, then shift left
    always_comb begin
        adj_c = shreg_q;
        for (int unsigned n = 0; n < NIB_N; n++) begin
            if (adj_c[VAL_W + 4*n +: 4] >= 4'd5)
                adj_c[VAL_W + 4*n +: 4] = adj_c[VAL_W + 4*n +: 4] + 4'd3;
        end
        step_c = {adj_c[SH_W-2:0], 1'b0};
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        bcd_d      = bcd_q;
        blank_d    = blank_q;
        ovf_d      = ovf_q;
        shreg_d    = shreg_q;
        iter_d     = iter_q;
        ovf_pend_d = ovf_pend_q;
        dwell_d    = dwell_q;

        unique case (state_q)
            IDLE: begin
                if (req_i != '0) begin
                    state_d    = CONVERT;
                    rr_ptr_d   = win_c;
                    grant_d    = win_onehot_c;
                    blank_d    = 1'b0;
                    shreg_d    = {20'd0, win_val_c};
                    iter_d     = '0;
                    ovf_pend_d = (win_val_c > MAX_DEC);
                end
            end
            CONVERT: begin
                shreg_d = step_c;
                iter_d  = iter_q + ITER_W'(1);
                if (iter_q == ITER_W'(15)) begin
                    bcd_d   = ovf_pend_q ? 16'h9999 : step_c[31:16];
                    ovf_d   = ovf_pend_q;
                    dwell_d = '0;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                dwell_d = dwell_q + CNT_W'(1);
                if (dwell_q == CNT_W'(DWELL_CYCLES - 1)) begin
                    if (req_i != '0) begin
                        state_d    = CONVERT;
                        rr_ptr_d   = win_c;
                        grant_d    = win_onehot_c;
                        shreg_d    = {20'd0, win_val_c};
                        iter_d     = '0;
                        ovf_pend_d = (win_val_c > MAX_DEC);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        blank_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= PTR_W'(NUM_REQ - 1);
            grant_q    <= '0;
            bcd_q      <= 16'h0000;
            blank_q    <= 1'b1;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            shreg_q    <= '0;
            iter_q     <= '0;
            ovf_pend_q <= 1'b0;
            dwell_q    <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            bcd_q      <= bcd_d;
            blank_q    <= blank_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            shreg_q    <= shreg_d;
            iter_q     <= iter_d;
            ovf_pend_q <= ovf_pend_d;
            dwell_q    <= dwell_d;
        end
    end

    assign grant_o    = grant_q;
    assign bcd_out_o  = bcd_q;
    assign blank_o    = blank_q;
    assign overflow_o = ovf_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_ssd_display_scheduler.sv
// Bench for ssd_display_scheduler: directed scenarios plus random traffic, checked
// each cycle against a slot-timer model that uses decimal arithmetic for BCD.
module tb_ssd_display_scheduler;

    localparam int N     = 4;
    localparam int DWELL = 8;
    localparam int CONV  = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [15:0]     val [N];
    logic [16*N-1:0] value_flat;
    logic [N-1:0]    grant;
    logic [15:0]     bcd_out;
    logic            blank, overflow, busy;

    int total = 0;
    int bad   = 0;

    assign value_flat = {val[3], val[2], val[1], val[0]};

    ssd_display_scheduler #(.NUM_REQ(N), .DWELL_CYCLES(DWELL), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req_i(req), .value_flat_i(value_flat),
        .grant_o(grant), .bcd_out_o(bcd_out), .blank_o(blank),
        .overflow_o(overflow), .busy_o(busy)
    );

    always #5 clk = ~clk;

    // Model: an owner holds the display for CONV+DWELL edges after its grant edge
    int          m_owner, m_t, m_rr;
    logic [15:0] m_val, m_bcd;
    logic        m_ovf;

    function automatic int pick(input logic [N-1:0] r, input int rr);
        for (int off = 1; off <= N; off++) begin
            if (r[(rr + off) % N]) return (rr + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        if (v > 9999) return 16'h9999;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic grab();
        m_owner = pick(req, m_rr);
        m_rr    = m_owner;
        m_val   = val[m_owner];
        m_t     = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1; m_t = 0; m_rr = N - 1; m_bcd = 16'h0000; m_ovf = 1'b0; m_val = '0;
        end else if (m_owner < 0) begin
            if (req != '0) grab();
        end else begin
            m_t++;
            if (m_t == CONV) begin
                m_bcd = to_bcd(int'(m_val));
                m_ovf = (m_val > 16'd9999);
            end
            if (m_t == CONV + DWELL) begin
                if (req != '0) grab();
                else m_owner = -1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
        chk("grant",    32'(grant),    32'(eg));
        chk("blank",    32'(blank),    32'(m_owner < 0));
        chk("busy",     32'(busy),     32'(m_owner >= 0));
        chk("bcd_out",  32'(bcd_out),  32'(m_bcd));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_model();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_bcd",   32'(bcd_out), 32'h0);
        chk("rst_blank", 32'(blank), 32'h1);
        chk("rst_busy",  32'(busy), 32'h0);
        chk("rst_ovf",   32'(overflow), 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_val();
        unsigned_case: case ($urandom_range(0, 4))
            0: return 16'($urandom);
            1: return 16'd9999;
            2: return 16'd10000;
            3: return 16'd0;
            default: return 16'($urandom_range(0, 9999));
        endcase
    endfunction

    initial begin
        for (int i = 0; i < N; i++) val[i] = '0;
        rst = 1'b1;
        #12;
        do_reset();

        // Single requester converting 1234, then value change mid-conversion
        req = 4'b0001; val[0] = 16'd1234;
        step(1);
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy",  32'(busy), 32'h1);
        chk("t1_blank", 32'(blank), 32'h0);
        step(15);
        chk("t1_bcd_hold", 32'(bcd_out), 32'h0);
        step(1);
        chk("t1_bcd", 32'(bcd_out), 32'h1234);
        step(DWELL);
        val[0] = 16'd42;
        step(2 * (CONV + DWELL) - DWELL);
        chk("t4_bcd", 32'(bcd_out), 32'h0042);

        // Saturation and boundaries
        val[0] = 16'd65535; step(2 * (CONV + DWELL));
        chk("t3_sat",     32'(bcd_out), 32'h9999);
        chk("t3_sat_ovf", 32'(overflow), 32'h1);
        val[0] = 16'd9999;  step(2 * (CONV + DWELL));
        chk("t3_9999_ovf", 32'(overflow), 32'h0);
        val[0] = 16'd0;     step(2 * (CONV + DWELL));
        chk("t3_zero", 32'(bcd_out), 32'h0);

        // Drop all requests: owner finishes its dwell, then idle with result kept
        step(CONV + 2);
        req = '0;
        step(2 * (CONV + DWELL));
        chk("t5_blank", 32'(blank), 32'h1);
        chk("t5_busy",  32'(busy), 32'h0);

        // Alternation between requesters 1 and 3
        do_reset();
        val[1] = 16'd77; val[3] = 16'd8001;
        req = 4'b1010;
        step(1);
        chk("t2_first", 32'(grant), 32'h2);
        step(CONV + DWELL);
        chk("t2_second", 32'(grant), 32'h8);
        step(CONV + DWELL);
        chk("t2_third", 32'(grant), 32'h2);
        step(CONV + DWELL);

        // Reset in the middle of a conversion
        req = 4'b0110;
        step(5);
        do_reset();
        step(1);
        chk("t6_first", 32'(grant), 32'h2);
        step(CONV + DWELL);

        // Random traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) req = N'($urandom);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 15) == 0) val[i] = rand_val();
            if ($urandom_range(0, 399) == 0) do_reset();
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
